systolic_job_sched: RTL and testbench
=====================================

SYSTOLIC_JOB_SCHED -- requirements
Module: systolic_job_sched

Interface
REQ-001 SHALL have parameter size, default 4, meaning array dimension (the array has size x size PEs).
REQ-002 SHALL have parameter nbits, default 16, meaning data word width.
REQ-003 SHALL have parameter DRAIN_CYC, default 3*size, meaning wait cycles between the end of load and result readout.
REQ-004 SHALL have the following ports, one per line as name direction width meaning:
- clk  in  1  clock; one clock domain; all logic on the rising edge.
- rst  in  1  synchronous, active-low reset.
- job_val  in  2  per-requester job request.
- job_rdy  out  2  per-requester job accept.
- x_msg  in  2*nbits  per-requester x stream, requester i in bits [i*nbits +: nbits].
- x_val  in  2  x valid.
- x_rdy  out  2  x ready.
- w_msg  in  2*nbits  per-requester w stream.
- w_val  in  2  w valid.
- w_rdy  out  2  w ready.
- arr_x_msg  out  nbits  to the array x input.
- arr_x_val  out  1  array x valid.
- arr_x_rdy  in  1  array x ready.
- arr_w_msg  out  nbits  to the array w input.
- arr_w_val  out  1  array w valid.
- arr_w_rdy  in  1  array w ready.
- arr_rsel  out  clog2(size)  array output row select.
- arr_csel  out  clog2(size)  array output column select.
- arr_out  in  nbits  selected array result.
- res_msg  out  nbits  result word.
- res_id  out  1  owner of the result.
- res_last  out  1  final word of the job.
- res_val  out  1  result valid.
- res_rdy  in  1  result ready.
- busy  out  1  state is not IDLE.
- job_cycles  out  32  cycle count of the last completed job.

Function
REQ-005 SHALL implement the states IDLE, LOAD, DRAIN and READ.
REQ-006 In IDLE, SHALL grant one requester when any job_val bit is high: a single request wins; on a tie, the requester matching prio wins; the grant drives job_rdy[owner]=1 for that cycle, latches owner, and moves to LOAD next cycle.
REQ-007 SHALL hold job_rdy at 0 in every state other than IDLE.
REQ-008 In LOAD, SHALL drive arr_x_msg/arr_x_val from x of the owner and x_rdy[owner]=arr_x_rdy; same for w; the non-owner's x_rdy and w_rdy SHALL be 0.
REQ-009 SHALL count x fires (val&&rdy) and w fires independently up to size*size each; once a count is reached, that stream's owner rdy and arr val SHALL be forced to 0.
REQ-010 SHALL move LOAD->DRAIN in the cycle after both counts reach size*size, including when both complete in the same cycle.
REQ-011 In DRAIN, SHALL wait exactly DRAIN_CYC cycles, then move to READ with rsel=csel=0.
REQ-012 In READ, SHALL assert res_val=1, with res_msg=arr_out (combinational), res_id=owner, and res_last=1 only at rsel=csel=size-1.
REQ-013 On a res fire, SHALL increment csel; at size-1, csel wraps to 0 and rsel increments; a stalled res_rdy SHALL hold rsel, csel and res_msg stable.
REQ-014 On the fire with res_last, SHALL go to IDLE and set prio to ~owner (round-robin).
REQ-015 arr_x_val, arr_w_val, all x_rdy and w_rdy SHALL be 0 outside LOAD; res_val SHALL be 0 outside READ.
REQ-016 A job_val deassert after acceptance SHALL have no effect; an accepted job always runs to completion.

Reset
REQ-017 While rst=0 at a clock edge, SHALL enter IDLE with owner=0, prio=0, all counters=0 and rsel=csel=0.
REQ-018 Reset asserted mid-job SHALL abort the job with no further res fire; all outputs SHALL be 0 in the cycle after the reset edge; job_cycles SHALL reset to 0.

Configuration
REQ-019 With SYSTOLIC_JOB_SCHED_PERF_EN defined, SHALL count cycles from the job_rdy fire cycle (counted as 1) through the res_last fire cycle inclusive, saturating at 2^32-1, and SHALL load job_cycles with that count on completion.
REQ-020 Without SYSTOLIC_JOB_SCHED_PERF_EN, job_cycles SHALL be constant 0 and no counter logic SHALL be instantiated.

Verification
REQ-021 size=4, job_val=01, streams always valid, sink always ready -> exactly 16 x fires and 16 w fires, DRAIN 12 cycles, 16 results with res_id=0 and res_last on the 16th.
REQ-022 job_val=11 held at reset exit -> requester 0 served first and requester 1 second; a third request from both -> requester 0 again.
REQ-023 x finishes 5 cycles before w -> x_rdy drops after the 16th x fire, and DRAIN starts the cycle after the 16th w fire.
REQ-024 res_rdy toggled 1,0,0,1 in READ -> no duplicated or skipped (rsel,csel) indices and res_msg stable during the stall.
REQ-025 rst=0 for one cycle during READ at index 7 -> IDLE, res_val=0, and a new job starts cleanly from index 0.
REQ-026 PERF_EN with zero-stall job, size=4 -> job_cycles=1+16+12+16 (±1 per the defined boundaries, checked exactly against the model).

Source files
------------

// File: rtl/systolic_job_sched.sv
// Two-requester job scheduler feeding one systolic array: grant, stream load, drain wait, result readout.
// Optional job cycle counter is enabled by defining SYSTOLIC_JOB_SCHED_PERF_EN.
module systolic_job_sched #(
    parameter int size      = 4,
    parameter int nbits     = 16,
    parameter int DRAIN_CYC = 3*size
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [1:0]               job_val,
    output logic [1:0]               job_rdy,
    input  logic [2*nbits-1:0]       x_msg,
    input  logic [1:0]               x_val,
    output logic [1:0]               x_rdy,
    input  logic [2*nbits-1:0]       w_msg,
    input  logic [1:0]               w_val,
    output logic [1:0]               w_rdy,
    output logic [nbits-1:0]         arr_x_msg,
    output logic                     arr_x_val,
    input  logic                     arr_x_rdy,
    output logic [nbits-1:0]         arr_w_msg,
    output logic                     arr_w_val,
    input  logic                     arr_w_rdy,
    output logic [$clog2(size)-1:0]  arr_rsel,
    output logic [$clog2(size)-1:0]  arr_csel,
    input  logic [nbits-1:0]         arr_out,
    output logic [nbits-1:0]         res_msg,
    output logic                     res_id,
    output logic                     res_last,
    output logic                     res_val,
    input  logic                     res_rdy,
    output logic                     busy,
    output logic [31:0]              job_cycles
);
    localparam int SW = $clog2(size);
    localparam int NW = $clog2(size*size+1);
    localparam logic [NW-1:0] NTOT  = NW'(size*size);
    localparam logic [NW-1:0] NLAST = NW'(size*size-1);
    localparam logic [SW-1:0] SMAX  = SW'(size-1);

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, READ} state_t;

    state_t          r_state;
    logic            r_owner;
    logic            r_prio;
    logic            r_hold;
    logic [NW-1:0]   r_xcnt;
    logic [NW-1:0]   r_wcnt;
    logic [31:0]     r_dcnt;
    logic [SW-1:0]   r_rsel;
    logic [SW-1:0]   r_csel;

    logic w_grant, w_gid;
    logic w_xact, w_wact, w_xsrc_val, w_wsrc_val;
    logic w_xfire, w_wfire, w_xdone, w_wdone;
    logic w_last, w_rfire;

    // r_hold keeps every output quiet for the first cycle after a reset edge
    assign w_grant    = (r_state == IDLE) && !r_hold && (|job_val);
    assign w_gid      = (job_val == 2'b11) ? r_prio : job_val[1];
    assign w_xact     = (r_state == LOAD) && (r_xcnt != NTOT);
    assign w_wact     = (r_state == LOAD) && (r_wcnt != NTOT);
    assign w_xsrc_val = r_owner ? x_val[1] : x_val[0];
    assign w_wsrc_val = r_owner ? w_val[1] : w_val[0];
    assign w_xfire    = w_xact && w_xsrc_val && arr_x_rdy;
    assign w_wfire    = w_wact && w_wsrc_val && arr_w_rdy;
    assign w_xdone    = (r_xcnt == NTOT) || ((r_xcnt == NLAST) && w_xfire);
    assign w_wdone    = (r_wcnt == NTOT) || ((r_wcnt == NLAST) && w_wfire);
    assign w_last     = (r_rsel == SMAX) && (r_csel == SMAX);
    assign w_rfire    = (r_state == READ) && res_rdy;

    always_comb begin
        job_rdy = 2'b00;
        if (w_grant) job_rdy[w_gid] = 1'b1;
        x_rdy = 2'b00;
        if (w_xact) x_rdy[r_owner] = arr_x_rdy;
        w_rdy = 2'b00;
        if (w_wact) w_rdy[r_owner] = arr_w_rdy;
    end

    assign arr_x_val = w_xact && w_xsrc_val;
    assign arr_w_val = w_wact && w_wsrc_val;
    assign arr_x_msg = (r_state != LOAD) ? '0 : (r_owner ? x_msg[2*nbits-1:nbits] : x_msg[nbits-1:0]);
    assign arr_w_msg = (r_state != LOAD) ? '0 : (r_owner ? w_msg[2*nbits-1:nbits] : w_msg[nbits-1:0]);
    assign arr_rsel  = r_rsel;
    assign arr_csel  = r_csel;
    assign res_val   = (r_state == READ);
    assign res_msg   = res_val ? arr_out : '0;
    assign res_id    = res_val && r_owner;
    assign res_last  = res_val && w_last;
    assign busy      = (r_state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_owner <= 1'b0;
            r_prio  <= 1'b0;
            r_hold  <= 1'b1;
            r_xcnt  <= '0;
            r_wcnt  <= '0;
            r_dcnt  <= '0;
            r_rsel  <= '0;
            r_csel  <= '0;
        end else begin
            r_hold <= 1'b0;
            case (r_state)
                IDLE: if (w_grant) begin
                    r_owner <= w_gid;
                    r_xcnt  <= '0;
                    r_wcnt  <= '0;
                    r_state <= LOAD;
                end
                LOAD: begin
                    if (w_xfire) r_xcnt <= r_xcnt + 1'b1;
                    if (w_wfire) r_wcnt <= r_wcnt + 1'b1;
                    if (w_xdone && w_wdone) begin
                        r_dcnt  <= '0;
                        r_state <= DRAIN;
                    end
                end
                DRAIN: if (r_dcnt == 32'(DRAIN_CYC-1)) begin
                    r_rsel  <= '0;
                    r_csel  <= '0;
                    r_state <= READ;
                end else begin
                    r_dcnt <= r_dcnt + 32'd1;
                end
                READ: if (w_rfire) begin
                    if (w_last) begin
                        r_rsel  <= '0;
                        r_csel  <= '0;
                        r_prio  <= ~r_owner;
                        r_state <= IDLE;
                    end else if (r_csel == SMAX) begin
                        r_csel <= '0;
                        r_rsel <= r_rsel + 1'b1;
                    end else begin
                        r_csel <= r_csel + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef SYSTOLIC_JOB_SCHED_PERF_EN
    logic [31:0] r_perf;
    logic [31:0] r_jc;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // the grant cycle counts as 1; the completing fire cycle is added on load
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_perf <= '0;
            r_jc   <= '0;
        end else begin
            if (w_grant) r_perf <= 32'd1;
            else if (r_state != IDLE) r_perf <= sat_inc(r_perf);
            if (w_rfire && w_last) r_jc <= sat_inc(r_perf);
        end
    end

    assign job_cycles = r_jc;
`else
    assign job_cycles = '0;
`endif
endmodule

// File: tb/tb_systolic_job_sched.sv
// Randomized self-checking bench for systolic_job_sched with a transaction-level job model.
module tb_systolic_job_sched;
    localparam int SZ = 4;
    localparam int NB = 16;
    localparam int N  = SZ*SZ;
    localparam int DR = 3*SZ;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [1:0]      job_val, job_rdy;
    logic [2*NB-1:0] x_msg, w_msg;
    logic [1:0]      x_val, x_rdy, w_val, w_rdy;
    logic [NB-1:0]   arr_x_msg, arr_w_msg, arr_out, res_msg;
    logic            arr_x_val, arr_x_rdy, arr_w_val, arr_w_rdy;
    logic [1:0]      arr_rsel, arr_csel;
    logic            res_id, res_last, res_val, res_rdy, busy;
    logic [31:0]     job_cycles;

    int nchk = 0, npass = 0;
    int cyc = 0;
    logic [15:0] salt = 16'h0;
    int  x_seq[2], w_seq[2];
    bit  in_job, done, stall_prev, rnd;
    logic own, mprio, post_busy, outs_or;
    int  xcnt, wcnt, rcnt, first_res, lastx, lastw, done_cyc, stray, rrmode, w_hold_until;
    logic [3:0]  prev_idx, rpat;
    logic [15:0] prev_msg;
    logic [1:0]  gnt, xsf, wsf;
    logic [31:0] post_jc;

    function automatic logic [15:0] mkw(bit is_w, logic id, int seq);
        return {is_w, id, 14'(seq)};
    endfunction

    // contents the fake array returns for a given cell
    function automatic logic [15:0] amodel(logic [1:0] r, logic [1:0] c, logic [15:0] s);
        return s + 16'(r)*16'd40 + 16'(c)*16'd3 + 16'(r)*16'(c)*16'd5;
    endfunction

    assign arr_out = amodel(arr_rsel, arr_csel, salt);

    systolic_job_sched #(.size(SZ), .nbits(NB)) dut (
        .clk(clk), .rst(rst), .job_val(job_val), .job_rdy(job_rdy),
        .x_msg(x_msg), .x_val(x_val), .x_rdy(x_rdy),
        .w_msg(w_msg), .w_val(w_val), .w_rdy(w_rdy),
        .arr_x_msg(arr_x_msg), .arr_x_val(arr_x_val), .arr_x_rdy(arr_x_rdy),
        .arr_w_msg(arr_w_msg), .arr_w_val(arr_w_val), .arr_w_rdy(arr_w_rdy),
        .arr_rsel(arr_rsel), .arr_csel(arr_csel), .arr_out(arr_out),
        .res_msg(res_msg), .res_id(res_id), .res_last(res_last),
        .res_val(res_val), .res_rdy(res_rdy), .busy(busy), .job_cycles(job_cycles)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic drive();
        for (int i = 0; i < 2; i++) begin
            x_val[i] = rnd ? 1'($urandom_range(0, 3) != 0) : 1'b1;
            w_val[i] = (cyc + 1 <= w_hold_until) ? 1'b0 :
                       (rnd ? 1'($urandom_range(0, 3) != 0) : 1'b1);
        end
        x_msg = {mkw(1'b0, 1'b1, x_seq[1]), mkw(1'b0, 1'b0, x_seq[0])};
        w_msg = {mkw(1'b1, 1'b1, w_seq[1]), mkw(1'b1, 1'b0, w_seq[0])};
        arr_x_rdy = rnd ? 1'($urandom_range(0, 2) != 0) : 1'b1;
        arr_w_rdy = rnd ? 1'($urandom_range(0, 2) != 0) : 1'b1;
        rpat = 4'b1001;
        case (rrmode)
            1:       res_rdy = rpat[(cyc + 1) % 4];
            2:       res_rdy = 1'($urandom_range(0, 2) != 0);
            default: res_rdy = 1'b1;
        endcase
    endtask

    task automatic cycle();
        logic xf, wf, rf;
        @(negedge clk);
        cyc++;
        xf = arr_x_val && arr_x_rdy;
        wf = arr_w_val && arr_w_rdy;
        rf = res_val && res_rdy;
        outs_or = |{job_rdy, x_rdy, w_rdy, arr_x_msg, arr_x_val, arr_w_msg, arr_w_val, arr_rsel,
                    arr_csel, res_msg, res_id, res_last, res_val, busy, job_cycles};
        if (in_job) begin
            if (x_rdy[~own] || w_rdy[~own]) stray++;
            if ((x_val[own] && x_rdy[own]) != xf) stray++;
            if ((w_val[own] && w_rdy[own]) != wf) stray++;
            if (xcnt >= N && (x_rdy[own] || arr_x_val)) stray++;
            if (wcnt >= N && (w_rdy[own] || arr_w_val)) stray++;
            if (res_val && (arr_x_val || arr_w_val || job_rdy != 2'b00)) stray++;
            if (xf) begin
                chk("xdata", 32'(arr_x_msg), 32'(mkw(1'b0, own, x_seq[own])));
                xcnt++; lastx = cyc;
            end
            if (wf) begin
                chk("wdata", 32'(arr_w_msg), 32'(mkw(1'b1, own, w_seq[own])));
                wcnt++; lastw = cyc;
            end
            if (res_val && first_res < 0) first_res = cyc;
            if (res_val && stall_prev) begin
                chk("stall_idx", 32'({arr_rsel, arr_csel}), 32'(prev_idx));
                chk("stall_msg", 32'(res_msg), 32'(prev_msg));
            end
            if (rf) begin
                chk("res_idx", 32'({arr_rsel, arr_csel}), 32'(rcnt));
                chk("res_msg", 32'(res_msg), 32'(amodel(2'(rcnt / SZ), 2'(rcnt % SZ), salt)));
                chk("res_id", 32'(res_id), 32'(own));
                chk("res_last", 32'(res_last), 32'(rcnt == N - 1));
                rcnt++;
                if (res_last) begin done = 1'b1; done_cyc = cyc; end
            end
            stall_prev = res_val && !res_rdy;
            prev_idx   = {arr_rsel, arr_csel};
            prev_msg   = res_msg;
        end else begin
            if (|{x_rdy, w_rdy, arr_x_val, arr_w_val, res_val}) stray++;
        end
        xsf = x_val & x_rdy;
        wsf = w_val & w_rdy;
        gnt = job_rdy;
        @(posedge clk);
        #1;
        post_busy = busy;
        post_jc   = job_cycles;
        for (int i = 0; i < 2; i++) begin
            if (xsf[i]) x_seq[i]++;
            if (wsf[i]) w_seq[i]++;
        end
        drive();
    endtask

    task automatic run_job(input logic [1:0] req, input bit drop, input bit rmode, input int rrm,
                           input int wdel, input int abort_at, input bit zchk);
        logic expo;
        int   g, expjc;
        bit   aborted;
        expo = (req == 2'b11) ? mprio : req[1];
        job_val = req; rnd = rmode; rrmode = rrm; salt = 16'($urandom);
        w_hold_until = -1;
        drive();
        gnt = 2'b00;
        for (int k = 0; k < 40 && gnt == 2'b00; k++) cycle();
        if (gnt == 2'b00) begin
            chk("grant_timeout", 32'd0, 32'd1);
            return;
        end
        chk("grant", 32'(gnt), expo ? 32'd2 : 32'd1);
        own = gnt[1]; g = cyc; in_job = 1'b1;
        xcnt = 0; wcnt = 0; rcnt = 0; first_res = -1; lastx = -1; lastw = -1;
        done = 1'b0; stall_prev = 1'b0; stray = 0; done_cyc = -1;
        w_hold_until = cyc + wdel;
        if (drop) job_val = 2'b00;
        drive();
        aborted = 1'b0;
        for (int k = 0; k < 800 && !done && !aborted; k++) begin
            cycle();
            if (abort_at >= 0 && rcnt == abort_at && first_res >= 0) begin
                rst = 1'b0; res_rdy = 1'b0;
                cycle();
                rst = 1'b1; in_job = 1'b0;
                cycle();
                chk("rst_quiet", 32'(outs_or), 32'd0);
                chk("abort_res_cnt", 32'(rcnt), 32'(abort_at));
                chk("abort_stray", 32'(stray), 32'd0);
                mprio = 1'b0; stray = 0;
                aborted = 1'b1;
            end
        end
        if (aborted) return;
        in_job = 1'b0;
        if (!done) begin
            chk("job_timeout", 32'd0, 32'd1);
            return;
        end
        chk("busy_end", 32'(post_busy), 32'd0);
        chk("xfires", 32'(xcnt), 32'(N));
        chk("wfires", 32'(wcnt), 32'(N));
        chk("rfires", 32'(rcnt), 32'(N));
        chk("drain_gap", 32'(first_res - (lastx > lastw ? lastx : lastw)), 32'(DR + 1));
        chk("stray", 32'(stray), 32'd0);
        if (wdel > 0 && !rmode) chk("w_lag", 32'(lastw - lastx), 32'(wdel));
        if (zchk) chk("zero_stall_len", 32'(done_cyc - g + 1), 32'(1 + N + DR + N));
`ifdef SYSTOLIC_JOB_SCHED_PERF_EN
        expjc = done_cyc - g + 1;
`else
        expjc = 0;
`endif
        chk("job_cycles", post_jc, 32'(expjc));
        mprio = ~own;
    endtask

    initial begin
        rst = 1'b0; job_val = 2'b11; rnd = 1'b0; rrmode = 0; w_hold_until = -1;
        x_seq[0] = 0; x_seq[1] = 0; w_seq[0] = 0; w_seq[1] = 0;
        in_job = 1'b0; mprio = 1'b0; own = 1'b0; stray = 0;
        drive();
        repeat (3) cycle();
        chk("rst_outputs", 32'(outs_or), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_jc", job_cycles, 32'd0);
        chk("rst_sel", 32'({arr_rsel, arr_csel}), 32'd0);
        chk("rst_stray", 32'(stray), 32'd0);
        rst = 1'b1;
        // both requesting at reset exit: round-robin 0, 1, 0
        run_job(2'b11, 1'b0, 1'b0, 0, 0, -1, 1'b1);
        run_job(2'b11, 1'b0, 1'b0, 0, 0, -1, 1'b0);
        run_job(2'b11, 1'b0, 1'b0, 0, 0, -1, 1'b0);
        run_job(2'b01, 1'b1, 1'b0, 0, 0, -1, 1'b1);
        run_job(2'b10, 1'b1, 1'b0, 0, 5, -1, 1'b0);
        run_job(2'b01, 1'b1, 1'b0, 1, 0, -1, 1'b0);
        for (int j = 0; j < 6; j++)
            run_job(2'($urandom_range(1, 3)), 1'($urandom_range(0, 1)), 1'b1, 2, 0, -1, 1'b0);
        run_job(2'b10, 1'b1, 1'b0, 0, 0, 7, 1'b0);
        run_job(2'b11, 1'b1, 1'b0, 2, 0, -1, 1'b0);
        run_job(2'b11, 1'b1, 1'b1, 1, 0, -1, 1'b0);
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule
